// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// State encoding, default operand width and bit-counter sizing.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Wide enough to hold the value WIDTH itself, so the count never wraps.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder cell, purely combinational.
// Shared by every bit position of the serial adder.
module fa_cell (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    assign sum      = a ^ b ^ carryin;
    assign carryout = (a & b) | (carryin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, IDLE/RUN/DONE control.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range 2..32");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_s;
    logic fa_co;

    // Operands shift right so bit k always sits at position 0 on RUN edge k.
    fa_cell u_fa (
        .sum      (fa_s),
        .carryout (fa_co),
        .a        (a_q[0]),
        .b        (b_q[0]),
        .carryin  (carry_q)
    );

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this last edge
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Expected results come from a behavioural add model via a scoreboard queue.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] oa, input logic [W-1:0] ob,
                            input logic oc);
        logic [W:0] full;
        exp_t e;
        full = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        e.s = full[W-1:0];
        e.c = full[W];
        e.v = (oa[W-1] == ob[W-1]) && (full[W-1] != oa[W-1]);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, output exp_t e);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: got empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.s));
            chk({tag, "_cout"}, 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
`endif
        end else begin
            e.s = 'x;
            e.c = 1'bx;
            e.v = 1'bx;
        end
    endtask

    // One operation from IDLE; optional disturbance of start/a/b in RUN.
    task automatic run_op(input string tag, input logic [W-1:0] oa,
                          input logic [W-1:0] ob, input logic oc,
                          input bit disturb);
        int n;
        int busyc;
        bit seen;
        bit quiet;
        exp_t e;
        a = oa;
        b = ob;
        cin = oc;
        push_exp(oa, ob, oc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busyc = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busyc++;
                if (disturb && n == 3) begin
                    start = 1'b1;
                    a = 8'hFF;
                    b = 8'h00;
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(W + 1));
        chk({tag, "_busy"}, 32'(busyc), 32'(W));
        pop_check(tag, e);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'({busy, done}), 32'd0);
        chk({tag, "_hold"}, 32'({cout, sum}), 32'({e.c, e.s}));
        if (disturb) begin
            quiet = 1'b1;
            repeat (12) begin
                @(negedge clk);
                if (busy || done) quiet = 1'b0;
            end
            chk({tag, "_nosecond"}, 32'(quiet), 32'd1);
        end
    endtask

    initial begin
        int n;
        int dn;
        int last;
        int idx;
        bit quiet;
        exp_t e;
        logic [W-1:0] ba [3];
        logic [W-1:0] bb [3];

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op("opff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("opff00c", 8'hFF, 8'h00, 1'b1, 1'b0);
        run_op("disturb", 8'h10, 8'h20, 1'b0, 1'b1);

        // Abort mid-RUN with asynchronous reset.
        a = 8'h33;
        b = 8'h44;
        cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_inrun", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) quiet = 1'b0;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) quiet = 1'b0;
        end
        chk("abort_nodone", 32'(quiet), 32'd1);
        run_op("postrst", 8'h01, 8'h01, 1'b0, 1'b0);

        // Back-to-back with start held high.
        ba[0] = 8'hC3; bb[0] = 8'h5E;
        ba[1] = 8'h0F; bb[1] = 8'hF1;
        ba[2] = 8'h80; bb[2] = 8'h7F;
        a = ba[0];
        b = bb[0];
        cin = 1'b0;
        push_exp(ba[0], bb[0], 1'b0);
        idx = 1;
        start = 1'b1;
        n = 0;
        dn = 0;
        last = -1;
        while (dn < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (done) begin
                pop_check("b2b", e);
                if (last >= 0) chk("b2b_period", 32'(n - last), 32'(W + 2));
                last = n;
                dn++;
                if (idx < 3) begin
                    a = ba[idx];
                    b = bb[idx];
                    push_exp(ba[idx], bb[idx], 1'b0);
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(dn), 32'd3);
        chk("b2b_first", 32'(last - 2 * (W + 2)), 32'(W + 1));
        repeat (3) @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
        run_op("ovf7f01", 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op("ovf8080", 8'h80, 8'h80, 1'b0, 1'b0);
        run_op("ovf0101", 8'h01, 8'h01, 1'b0, 1'b0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 cin  input  1  carry-in; captured on an accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-011 cout  output  1  carry out of bit WIDTH-1; same hold rule as sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin with a single 1-bit full-adder cell, one bit per cycle, LSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at edge T SHALL do all of the following: latch a, b and cin; clear the bit counter; enter RUN.
REQ-015 In RUN, each edge SHALL perform all of the following:
- feed operand bit[k] of a and b, plus the carry register, to the cell;
- shift the cell sum into the MSB of the sum shift register;
- load the cell carry-out into the carry register;
- increment k.
REQ-016 After WIDTH RUN edges (T+1..T+WIDTH), the FSM SHALL enter DONE, and done SHALL be high for the cycle following edge T+WIDTH.
REQ-017 Latency from the accepted start edge to the done-high cycle SHALL be exactly WIDTH+1 edges, with no throughput overlap.
REQ-018 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing.
REQ-020 Changes to a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-021 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE.
REQ-022 sum and cout SHALL update only from the shift and carry registers; while in RUN they hold the partial or previous value, valid only when done=1 or afterwards.
REQ-023 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL NOT wrap during RUN.

Reset
REQ-024 rst_n=0 SHALL immediately force all of the following, regardless of state: state=IDLE; busy=0; done=0; sum=0; cout=0; counter=0; carry register=0; operand registers=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-026 After rst_n rises, the first start SHALL be accepted normally.

Configuration
REQ-027 The feature macro SHALL be SERIAL_ADDER_OVF_EN.
- When defined: an extra output ovf (1 bit) SHALL equal the carry into bit WIDTH-1 XOR cout (signed two's-complement overflow), with the same reset value (0) and hold rules as cout.
- When undefined: the port ovf SHALL be absent, and no related logic SHALL exist.

Structure
REQ-028 A shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE encoding), the default WIDTH constant, and the counter-width function.
REQ-029 The 1-bit full adder SHALL be a separate sub-module, fa_cell (sum, carryout, a, b, carryin), purely combinational, instantiated exactly once.

Verification
REQ-030 WIDTH=8; a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, then done pulse at the 9th edge, sum=0x96, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-032 Start with a=0x10, b=0x20; assert start again at RUN cycle 3 with a=0xFF, and change b to 0x00 during RUN -> single done, sum=0x30, cout=0, no second operation.
REQ-033 rst_n low at RUN cycle 4 -> busy=0 and sum=0 immediately, no done; next start with 0x01+0x01 -> sum=0x02 after 9 edges.
REQ-034 Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles (IDLE re-entry), each result correct.
REQ-035 With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> ovf=1, cout=0; 0x80+0x80 -> ovf=1, cout=1, sum=0x00; 0x01+0x01 -> ovf=0.
